hpb_wr_arb: RTL and testbench

HPB_WR_ARB -- requirements
Module: hpb_wr_arb

---
 rtl/hpb_pkg.sv | 13 +
 rtl/hpb_rr_arb.sv | 33 +++
 rtl/hpb_wr_arb.sv | 140 ++++++++++++++
 tb/tb_hpb_wr_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hpb_pkg.sv
// Shared definitions for the HPB write arbiter: FSM state encoding and default sizing.
package hpb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } hpb_state_e;

  localparam int HPB_RCB_RAM_WIDTH = 64;
  localparam int HPB_TIMEOUT_CYC   = 255;

endpackage

// File: rtl/hpb_rr_arb.sv
// Combinational round-robin selector: first requester strictly after ptr wins.
module hpb_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_vld
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest requester overwrites.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpb_wr_arb.sv
// Arbitrates NUM_REQ write requesters onto the single HPB write port of the RCB RAM,
// with a per-write timeout and a saturating count of timed-out writes.
module hpb_wr_arb
  import hpb_pkg::*;
#(
  parameter int RCB_RAM_WIDTH = HPB_RCB_RAM_WIDTH,
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_CYC   = HPB_TIMEOUT_CYC
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [NUM_REQ-1:0]                          req_addr,
  input  logic [NUM_REQ-1:0][RCB_RAM_WIDTH-1:0]       req_data,
  input  logic [NUM_REQ-1:0][RCB_RAM_WIDTH/8-1:0]     req_en,
  output logic [NUM_REQ-1:0]                          ack,
  output logic                                        err,
  output logic                                        hpb_wr_addr,
  output logic [RCB_RAM_WIDTH-1:0]                    hpb_wr_data,
  output logic [RCB_RAM_WIDTH/8-1:0]                  hpb_wr_en,
  output logic                                        hpb_wr_req,
  input  logic                                        rcb_wr_done,
  output logic                                        busy,
  output logic [15:0]                                 timeout_cnt
);

  localparam int BW = RCB_RAM_WIDTH / 8;
  localparam int IW = $clog2(NUM_REQ);

  hpb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         timeout_cnt_q, timeout_cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic                addr_q, addr_d;
  logic [RCB_RAM_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]       en_q, en_d;
  logic                wr_req_q, wr_req_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_vld;
  logic                timeout_hit;

  hpb_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // cnt_q counts completed WAIT cycles, so the current cycle is number cnt_q+1.
  assign timeout_hit = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYC);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    ack_d         = '0;
    err_d         = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    en_d          = en_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = WAIT;
          ptr_d   = arb_idx;
          gnt_d   = arb_gnt;
          cnt_d   = '0;
          addr_d  = req_addr[arb_idx];
          data_d  = req_data[arb_idx];
          en_d    = req_en[arb_idx];
        end
      end
      WAIT: begin
        if (rcb_wr_done) begin
          state_d = ACK;
          ack_d   = gnt_q;
        end else if (timeout_hit) begin
          state_d       = ACK;
          ack_d         = gnt_q;
          err_d         = 1'b1;
          timeout_cnt_d = (timeout_cnt_q == 16'hFFFF) ? timeout_cnt_q : timeout_cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_req_d = (state_d == WAIT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= IW'(NUM_REQ - 1);
      gnt_q         <= '0;
      cnt_q         <= '0;
      timeout_cnt_q <= '0;
      ack_q         <= '0;
      err_q         <= 1'b0;
      addr_q        <= 1'b0;
      data_q        <= '0;
      en_q          <= '0;
      wr_req_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      en_q          <= en_d;
      wr_req_q      <= wr_req_d;
      busy_q        <= busy_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign hpb_wr_addr = addr_q;
  assign hpb_wr_data = data_q;
  assign hpb_wr_en   = en_q;
  assign hpb_wr_req  = wr_req_q;
  assign busy        = busy_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_hpb_wr_arb.sv
// Directed bench for hpb_wr_arb: reset, stray done, contention, single write,
// timeout, done/timeout coincidence and reset during WAIT.
module tb_hpb_wr_arb;

  logic              clk;
  logic              reset_n;
  logic [3:0]        req;
  logic [3:0]        req_addr;
  logic [3:0][63:0]  req_data;
  logic [3:0][7:0]   req_en;
  logic [3:0]        ack;
  logic              err;
  logic              hpb_wr_addr;
  logic [63:0]       hpb_wr_data;
  logic [7:0]        hpb_wr_en;
  logic              hpb_wr_req;
  logic              rcb_wr_done;
  logic              busy;
  logic [15:0]       timeout_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  hpb_wr_arb #(.RCB_RAM_WIDTH(64), .NUM_REQ(4), .TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_en      (req_en),
    .ack         (ack),
    .err         (err),
    .hpb_wr_addr (hpb_wr_addr),
    .hpb_wr_data (hpb_wr_data),
    .hpb_wr_en   (hpb_wr_en),
    .hpb_wr_req  (hpb_wr_req),
    .rcb_wr_done (rcb_wr_done),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_oh;
    reset_n     = 1'b0;
    req         = '0;
    req_addr    = '0;
    req_data    = '0;
    req_en      = '0;
    rcb_wr_done = 1'b0;
    tick();
    tick();
    chk("rst_wr_req", 64'(hpb_wr_req), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tocnt", 64'(timeout_cnt), 64'd0);
    chk("rst_data", hpb_wr_data, 64'd0);
    chk("rst_en", 64'(hpb_wr_en), 64'd0);
    chk("rst_addr", 64'(hpb_wr_addr), 64'd0);
    reset_n = 1'b1;

    // Stray done in IDLE
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_ack", 64'(ack), 64'd0);
    chk("stray_wr_req", 64'(hpb_wr_req), 64'd0);
    tick();
    chk("stray_ack2", 64'(ack), 64'd0);

    // Contention: all request, done held high; expect 0,1,2,3,0
    for (int i = 0; i < 4; i++) begin
      req_data[i] = 64'hA000 + 64'(i);
      req_en[i]   = 8'(1 << i);
      req_addr[i] = i[0];
    end
    req         = 4'b1111;
    rcb_wr_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'(1 << (k % 4));
      tick();
      chk($sformatf("cont%0d_wr_req", k), 64'(hpb_wr_req), 64'd1);
      chk($sformatf("cont%0d_data", k), hpb_wr_data, 64'hA000 + 64'(k % 4));
      chk($sformatf("cont%0d_en", k), 64'(hpb_wr_en), 64'(exp_oh));
      tick();
      chk($sformatf("cont%0d_ack", k), 64'(ack), 64'(exp_oh));
      chk($sformatf("cont%0d_err", k), 64'(err), 64'd0);
      chk($sformatf("cont%0d_ack_wr_req", k), 64'(hpb_wr_req), 64'd0);
      tick();
      chk($sformatf("cont%0d_idle_ack", k), 64'(ack), 64'd0);
      chk($sformatf("cont%0d_idle_busy", k), 64'(busy), 64'd0);
    end
    req         = 4'b0000;
    rcb_wr_done = 1'b0;
    tick();

    // Single write, done two cycles after hpb_wr_req rises
    req_addr[0] = 1'b1;
    req_data[0] = 64'hDEAD_BEEF_0123_4567;
    req_en[0]   = 8'hFF;
    req         = 4'b0001;
    tick();
    chk("single_wr_req", 64'(hpb_wr_req), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_addr", 64'(hpb_wr_addr), 64'd1);
    chk("single_data", hpb_wr_data, 64'hDEAD_BEEF_0123_4567);
    chk("single_en", 64'(hpb_wr_en), 64'hFF);
    tick();
    chk("single_wr_req2", 64'(hpb_wr_req), 64'd1);
    chk("single_noack", 64'(ack), 64'd0);
    tick();
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    chk("single_ack", 64'(ack), 64'b0001);
    chk("single_err", 64'(err), 64'd0);
    chk("single_ack_wr_req", 64'(hpb_wr_req), 64'd0);
    req = 4'b0000;
    tick();
    chk("single_ack_pulse", 64'(ack), 64'd0);
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_data_hold", hpb_wr_data, 64'hDEAD_BEEF_0123_4567);

    // Timeout on requester 1
    req = 4'b0010;
    tick();
    chk("to_wr_req1", 64'(hpb_wr_req), 64'd1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("to_wr_req%0d", c), 64'(hpb_wr_req), 64'd1);
      chk($sformatf("to_noack%0d", c), 64'(ack), 64'd0);
    end
    tick();
    chk("to_ack", 64'(ack), 64'b0010);
    chk("to_err", 64'(err), 64'd1);
    chk("to_tocnt", 64'(timeout_cnt), 64'd1);
    chk("to_wr_req_low", 64'(hpb_wr_req), 64'd0);
    req = 4'b0000;
    tick();
    chk("to_err_pulse", 64'(err), 64'd0);

    // Done coincides with the final WAIT cycle of requester 2
    req = 4'b0100;
    tick();
    tick();
    tick();
    tick();
    chk("coin_wr_req", 64'(hpb_wr_req), 64'd1);
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    chk("coin_ack", 64'(ack), 64'b0100);
    chk("coin_err", 64'(err), 64'd0);
    chk("coin_tocnt", 64'(timeout_cnt), 64'd1);
    req = 4'b0000;
    tick();

    // Reset during WAIT of requester 1; afterwards requester 0 must win over 3
    req = 4'b0010;
    tick();
    chk("rw_wr_req", 64'(hpb_wr_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_wr_req_drop", 64'(hpb_wr_req), 64'd0);
    chk("rw_busy_drop", 64'(busy), 64'd0);
    chk("rw_tocnt_clr", 64'(timeout_cnt), 64'd0);
    tick();
    chk("rw_noack", 64'(ack), 64'd0);
    reset_n = 1'b1;
    req     = 4'b1001;
    tick();
    chk("rw_regrant_data", hpb_wr_data, 64'hDEAD_BEEF_0123_4567);
    chk("rw_regrant_req", 64'(hpb_wr_req), 64'd1);
    rcb_wr_done = 1'b1;
    tick();
    rcb_wr_done = 1'b0;
    req         = 4'b0000;
    chk("rw_regrant_ack", 64'(ack), 64'b0001);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
